// File: rtl/soc_system_pll_rst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : soc_system_pll_rst_ctrl
// Description : Reset/lock sequencer for the refclk-fed PLL. It pulses the PLL
//               reset, qualifies a synchronised lock and releases sys_rst.
//               Optional macro PLL_RST_CTRL_LOCK_RECOVER_EN: lock loss in RUN
//               re-runs the sequence and adds the lock_loss_cnt port.
// Revision    : 1.0 - initial release
// ============================================================================
module soc_system_pll_rst_ctrl #(
    parameter int POR_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7,
    parameter int SYNC_STAGES   = 2
) (
    input  logic refclk,
    input  logic rst,
    input  logic pll_locked,
    input  logic clr_fault,
    output logic pll_rst,
    output logic sys_rst,
    output logic ready,
    output logic fault,
    output logic [$clog2(MAX_RETRIES + 1 + ((MAX_RETRIES == 0) ? 1 : 0)) - 1:0] retry_cnt
`ifdef PLL_RST_CTRL_LOCK_RECOVER_EN
    ,
    output logic [7:0] lock_loss_cnt
`endif
);

    localparam int c_RW   = $clog2(MAX_RETRIES + 1 + ((MAX_RETRIES == 0) ? 1 : 0));
    localparam int c_CMAX = (POR_CYCLES > LOCK_TIMEOUT)
                          ? ((POR_CYCLES > STABLE_CYCLES) ? POR_CYCLES : STABLE_CYCLES)
                          : ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
    localparam int c_CW   = $clog2(c_CMAX + 1);

    localparam logic [c_CW-1:0] c_POR_LAST    = c_CW'(POR_CYCLES - 1);
    localparam logic [c_CW-1:0] c_TO_LAST     = c_CW'(LOCK_TIMEOUT - 1);
    localparam logic [c_CW-1:0] c_STABLE_LAST = c_CW'(STABLE_CYCLES - 1);
    localparam logic [c_RW-1:0] c_RETRY_MAX   = c_RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lk_s;
    logic [c_CW-1:0]        r_cnt;
    logic [c_CW-1:0]        w_cnt_nxt;
    logic [c_RW-1:0]        r_retry_cnt;
    logic [c_RW-1:0]        w_retry_nxt;
    logic                   r_pll_rst;
    logic                   r_sys_rst;
    logic                   r_ready;
    logic                   r_fault;

    assign w_lk_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry_cnt;
        case (r_state)
            S_PLL_RST: begin
                if (r_cnt == c_POR_LAST) w_state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // A lock seen in the timeout cycle takes priority over a retry.
                if (w_lk_s) begin
                    w_state_nxt = S_STABLE;
                end else if (r_cnt == c_TO_LAST) begin
                    if (r_retry_cnt == c_RETRY_MAX) begin
                        w_state_nxt = S_FAULT;
                    end else begin
                        w_retry_nxt = r_retry_cnt + c_RW'(1);
                        w_state_nxt = S_PLL_RST;
                    end
                end
            end
            S_STABLE: begin
                if (!w_lk_s)                      w_state_nxt = S_WAIT_LOCK;
                else if (r_cnt == c_STABLE_LAST)  w_state_nxt = S_RUN;
            end
            S_RUN: begin
`ifdef PLL_RST_CTRL_LOCK_RECOVER_EN
                if (!w_lk_s) w_state_nxt = S_PLL_RST;
`else
                if (!w_lk_s) w_state_nxt = S_FAULT;
`endif
            end
            S_FAULT: begin
                if (clr_fault) begin
                    w_state_nxt = S_PLL_RST;
                    w_retry_nxt = '0;
                end
            end
            default: w_state_nxt = S_PLL_RST;
        endcase
        if (w_state_nxt == S_RUN) w_retry_nxt = '0;
    end

    // Counter restarts on every state change and only runs in timed states.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end else if (r_state == S_PLL_RST || r_state == S_WAIT_LOCK || r_state == S_STABLE) begin
            w_cnt_nxt = r_cnt + c_CW'(1);
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state     <= S_PLL_RST;
            r_cnt       <= '0;
            r_retry_cnt <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retry_cnt <= w_retry_nxt;
            r_pll_rst   <= (w_state_nxt == S_PLL_RST) || (w_state_nxt == S_FAULT);
            r_sys_rst   <= (w_state_nxt != S_RUN);
            r_ready     <= (w_state_nxt == S_RUN);
            r_fault     <= (w_state_nxt == S_FAULT);
        end
    end

`ifdef PLL_RST_CTRL_LOCK_RECOVER_EN
    logic [7:0] r_lock_loss_cnt;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_lock_loss_cnt <= 8'd0;
        end else if (r_state == S_RUN && !w_lk_s && r_lock_loss_cnt != 8'hFF) begin
            r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
        end
    end

    assign lock_loss_cnt = r_lock_loss_cnt;
`endif

    assign pll_rst   = r_pll_rst;
    assign sys_rst   = r_sys_rst;
    assign ready     = r_ready;
    assign fault     = r_fault;
    assign retry_cnt = r_retry_cnt;

endmodule
`default_nettype wire

// File: tb/tb_soc_system_pll_rst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_soc_system_pll_rst_ctrl
// Description : Directed self-checking bench for soc_system_pll_rst_ctrl
//               (POR=4, TIMEOUT=20, STABLE=8, RETRIES=2, SYNC=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_system_pll_rst_ctrl;

    localparam int c_POR     = 4;
    localparam int c_TIMEOUT = 20;
    localparam int c_STABLE  = 8;
    localparam int c_RETRIES = 2;
    localparam int c_SYNC    = 2;
    localparam int c_LOCK_LAT = c_SYNC + c_STABLE + 1;
    localparam int c_LOSS_LAT = c_SYNC + 1;
    localparam int c_BOUND   = 200;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       clr_fault;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;
`ifdef PLL_RST_CTRL_LOCK_RECOVER_EN
    logic [7:0] lock_loss_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n;
    logic r_seen_release;

    soc_system_pll_rst_ctrl #(
        .POR_CYCLES    (c_POR),
        .LOCK_TIMEOUT  (c_TIMEOUT),
        .STABLE_CYCLES (c_STABLE),
        .MAX_RETRIES   (c_RETRIES),
        .SYNC_STAGES   (c_SYNC)
    ) u_dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .clr_fault     (clr_fault),
        .pll_rst       (pll_rst),
        .sys_rst       (sys_rst),
        .ready         (ready),
        .fault         (fault),
        .retry_cnt     (retry_cnt)
`ifdef PLL_RST_CTRL_LOCK_RECOVER_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic wait_pll_rst(input logic val, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (pll_rst !== val && fault !== 1'b1 && cnt < c_BOUND);
    endtask

    task automatic wait_sys_rst(input logic val, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (sys_rst !== val && cnt < c_BOUND);
    endtask

    // Releases rst and expects the first pll_rst pulse to end after c_POR cycles.
    task automatic release_and_por(input string tag);
        int k;
        rst = 1'b0;
        wait_pll_rst(1'b0, k);
        check({tag, "_por_len"}, k, c_POR);
    endtask

    // Raises lock in WAIT_LOCK and expects release after the full qualification.
    task automatic lock_to_run(input string tag);
        int k;
        pll_locked = 1'b1;
        wait_sys_rst(1'b0, k);
        check({tag, "_lock_lat"}, k, c_LOCK_LAT);
        check({tag, "_ready"}, ready, 1);
        check({tag, "_retry"}, retry_cnt, 0);
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        clr_fault  = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_pll_rst", pll_rst, 1);
        check("rst_sys_rst", sys_rst, 1);
        check("rst_ready", ready, 0);
        check("rst_fault", fault, 0);
        check("rst_retry", retry_cnt, 0);

        // Test 1: nominal lock sequence
        release_and_por("t1");
        repeat (10) tick();
        check("t1_sys_rst_wait", sys_rst, 1);
        lock_to_run("t1");
        check("t1_pll_rst", pll_rst, 0);

        // Test 5b: clr_fault ignored in RUN
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        tick();
        check("t5b_ready", ready, 1);
        check("t5b_sys_rst", sys_rst, 0);
        check("t5b_fault", fault, 0);

        // Test 4: lock loss in RUN
        pll_locked = 1'b0;
        wait_sys_rst(1'b1, n);
        check("t4_loss_lat", n, c_LOSS_LAT);
        check("t4_ready", ready, 0);
        check("t4_pll_rst", pll_rst, 1);
`ifdef PLL_RST_CTRL_LOCK_RECOVER_EN
        check("t4_fault", fault, 0);
        check("t4_loss_cnt", lock_loss_cnt, 1);
        wait_pll_rst(1'b0, n);
        check("t4_por_len", n, c_POR);
        lock_to_run("t4_relock");
        check("t4_loss_cnt_run", lock_loss_cnt, 1);
`else
        check("t4_fault", fault, 1);
`endif

        // Test 2: no lock at all, retries then FAULT
        rst = 1'b1;
        pll_locked = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i <= c_RETRIES; i++) begin
            wait_pll_rst(1'b0, n);
            check($sformatf("t2_por_len%0d", i), n, c_POR);
            wait_pll_rst(1'b1, n);
            check($sformatf("t2_gap%0d", i), n, c_TIMEOUT);
            if (i < c_RETRIES) check($sformatf("t2_retry%0d", i), retry_cnt, i + 1);
        end
        check("t2_fault", fault, 1);
        check("t2_retry_final", retry_cnt, c_RETRIES);
        repeat (10) tick();
        check("t2_pll_rst_held", pll_rst, 1);
        check("t2_fault_held", fault, 1);
        check("t2_sys_rst", sys_rst, 1);

        // Test 5a: clr_fault leaves FAULT
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        check("t5a_fault", fault, 0);
        check("t5a_retry", retry_cnt, 0);
        check("t5a_pll_rst", pll_rst, 1);
        wait_pll_rst(1'b0, n);
        check("t5a_por_len", n, c_POR);

        // Test 6: async reset in WAIT_LOCK with a retry already used
        wait_pll_rst(1'b1, n);
        check("t6_gap", n, c_TIMEOUT);
        check("t6_retry_pre", retry_cnt, 1);
        wait_pll_rst(1'b0, n);
        repeat (7) tick();
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_pll_rst", pll_rst, 1);
        check("t6_async_sys_rst", sys_rst, 1);
        check("t6_async_retry", retry_cnt, 0);
        tick();
        release_and_por("t6");
        repeat (10) tick();
        lock_to_run("t6");

        // Test 3: lock glitch while in STABLE
        rst = 1'b1;
        pll_locked = 1'b0;
        tick();
        release_and_por("t3");
        wait_pll_rst(1'b1, n);
        check("t3_gap", n, c_TIMEOUT);
        wait_pll_rst(1'b0, n);
        r_seen_release = 1'b0;
        pll_locked = 1'b1;
        repeat (5) begin
            tick();
            if (sys_rst !== 1'b1) r_seen_release = 1'b1;
        end
        pll_locked = 1'b0;
        repeat (2) begin
            tick();
            if (sys_rst !== 1'b1) r_seen_release = 1'b1;
        end
        check("t3_no_early_release", r_seen_release, 0);
        check("t3_retry_held", retry_cnt, 1);
        lock_to_run("t3");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
